// File: rtl/vend_controller.sv
// Vending machine transaction sequencer: latches a product ID, collects coins,
// then holds a dispense, refund or error result for a fixed number of cycles.
module vend_controller #(
  parameter int NUM_PRODUCTS = 10,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int IDLE_TIMEOUT = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       coin_valid,
  input  logic [3:0] coin_value,
  input  logic       cancel,
  input  logic [3:0] price,
  input  logic       product_avail,
  output logic [3:0] id_sel,
  output logic [3:0] val_tot,
  output logic [3:0] change,
  output logic       release_product,
  output logic       back_money,
  output logic       coin_reject,
  output logic [1:0] err_code,
  output logic [2:0] state_now
);

  localparam int CMAX = (HOLD_CYCLES > IDLE_TIMEOUT) ? HOLD_CYCLES : IDLE_TIMEOUT;
  localparam int TW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [4:0]    NP        = 5'(NUM_PRODUCTS);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    CHECK    = 3'b001,
    COLLECT  = 3'b010,
    DISPENSE = 3'b011,
    REFUND   = 3'b100,
    ERROR    = 3'b101
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // Credit sum kept one bit wider so bit 4 flags a credit overflow.
  function automatic logic [4:0] coin_sum(input logic [3:0] a, input logic [3:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [4:0] sum;
  logic       coin_ok;
  logic       timed_out;
  logic       abort;

  always_comb begin
    sum       = coin_sum(val_tot, coin_value);
    coin_ok   = coin_valid && !cancel && !sum[4];
    timed_out = (timer == IDLE_LAST);
    // An accepted coin on the terminal cycle rescues the transaction.
    abort     = cancel || (timed_out && !coin_ok);
  end

  assign state_now = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      id_sel          <= '0;
      val_tot         <= '0;
      change          <= '0;
      err_code        <= '0;
      release_product <= 1'b0;
      back_money      <= 1'b0;
      coin_reject     <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          coin_reject <= coin_valid;
          if (key_valid) begin
            id_sel <= key_code;
            state  <= CHECK;
          end
        end
        CHECK: begin
          coin_reject <= coin_valid;
          timer       <= '0;
          if ({1'b0, id_sel} >= NP) begin
            state    <= ERROR;
            err_code <= 2'b01;
          end else if (!product_avail) begin
            state    <= ERROR;
            err_code <= 2'b10;
          end else if (price == 4'd0) begin
            state           <= DISPENSE;
            release_product <= 1'b1;
            change          <= '0;
          end else begin
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (abort) begin
            coin_reject <= coin_valid;
            timer       <= '0;
            if (val_tot != 4'd0) begin
              state      <= REFUND;
              back_money <= 1'b1;
              change     <= val_tot;
            end else begin
              state    <= ERROR;
              err_code <= 2'b11;
            end
          end else if (coin_ok) begin
            val_tot <= sum[3:0];
            timer   <= '0;
            if (sum >= {1'b0, price}) begin
              state           <= DISPENSE;
              release_product <= 1'b1;
              change          <= sum[3:0] - price;
            end
          end else begin
            coin_reject <= coin_valid;
            timer       <= timer + 1'b1;
          end
        end
        DISPENSE, REFUND, ERROR: begin
          coin_reject <= coin_valid;
          if (timer == HOLD_LAST) begin
            state           <= IDLE;
            timer           <= '0;
            id_sel          <= '0;
            val_tot         <= '0;
            change          <= '0;
            err_code        <= '0;
            release_product <= 1'b0;
            back_money      <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: a transaction-level model predicts each
// outcome, a monitor compares it when a result appears on the outputs.
module tb_vend_controller;

  localparam int NP   = 10;
  localparam int HOLD = 4;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       rst, key_valid, coin_valid, cancel, product_avail;
  logic [3:0] key_code, coin_value, price, id_sel, val_tot, change;
  logic       release_product, back_money, coin_reject;
  logic [1:0] err_code;
  logic [2:0] state_now;

  int errors = 0;
  int checks = 0;

  logic [3:0] price_tab [16];
  logic       avail_tab [16];

  assign price         = price_tab[id_sel];
  assign product_avail = avail_tab[id_sel];

  typedef struct {
    int kind;  // 0 dispense, 1 refund, 2 error
    int chg;
    int vt;
    int err;
    int id;
    int rej;
  } exp_t;

  typedef struct {
    bit coin;
    int v;
    bit cancel;
  } act_t;

  exp_t expq[$];
  act_t script[$];

  vend_controller #(
    .NUM_PRODUCTS(NP),
    .HOLD_CYCLES (HOLD),
    .IDLE_TIMEOUT(TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .cancel         (cancel),
    .price          (price),
    .product_avail  (product_avail),
    .id_sel         (id_sel),
    .val_tot        (val_tot),
    .change         (change),
    .release_product(release_product),
    .back_money     (back_money),
    .coin_reject    (coin_reject),
    .err_code       (err_code),
    .state_now      (state_now)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit coin, input int v, input bit cxl);
    act_t a;
    a.coin = coin; a.v = v; a.cancel = cxl;
    script.push_back(a);
  endtask

  function automatic exp_t abort_result(input exp_t e_in, input int credit);
    exp_t e = e_in;
    e.vt = credit;
    if (credit > 0) begin e.kind = 1; e.chg = credit; end
    else            begin e.kind = 2; e.err = 3; end
    return e;
  endfunction

  // Predicts the outcome of one purchase from the rules: credit accumulates
  // unless it would exceed 15; paying enough dispenses; cancel or TMO cycles
  // without an accepted coin refunds (or errors with no credit).
  function automatic exp_t model(input int id, input int pr, input bit av,
                                 input int pre_rej, output int ncyc);
    exp_t e;
    act_t a;
    int credit, t;
    e.kind = 2; e.chg = 0; e.vt = 0; e.err = 0; e.id = id; e.rej = pre_rej;
    ncyc = 0;
    if (id >= NP)       e.err = 1;
    else if (!av)       e.err = 2;
    else if (pr == 0)   e.kind = 0;
    else begin
      credit = 0;
      t = 0;
      for (int c = 0; c < 1000; c++) begin
        if (c < script.size()) a = script[c];
        else begin a.coin = 0; a.v = 0; a.cancel = 0; end
        ncyc = c + 1;
        if (a.cancel) begin
          if (a.coin) e.rej = e.rej + 1;
          return abort_result(e, credit);
        end
        if (a.coin && (credit + a.v <= 15)) begin
          credit = credit + a.v;
          t = 0;
          if (credit >= pr) begin
            e.kind = 0; e.chg = credit - pr; e.vt = credit;
            return e;
          end
        end else begin
          if (a.coin) e.rej = e.rej + 1;
          if (t == TMO - 1) return abort_result(e, credit);
          t++;
        end
      end
    end
    return e;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (state_now != 3'd0 && k < 300) begin
      tick();
      k++;
    end
    chk("return_idle", state_now, 0);
  endtask

  task automatic run_txn(input int id, input int pr, input bit av,
                         input bit pre_coin, input bit chk_coin);
    exp_t e;
    int n;
    price_tab[id] = 4'(pr);
    avail_tab[id] = av;
    e = model(id, pr, av, int'(pre_coin) + int'(chk_coin), n);
    expq.push_back(e);
    if (pre_coin) begin
      coin_valid = 1'b1; coin_value = 4'($urandom_range(1, 15));
      tick();
      coin_valid = 1'b0; coin_value = 4'd0;
    end
    key_valid = 1'b1; key_code = 4'(id);
    tick();
    key_valid = 1'b0; key_code = 4'd0;
    coin_valid = chk_coin; coin_value = 4'd3;
    tick();
    coin_valid = 1'b0; coin_value = 4'd0;
    for (int i = 0; i < n; i++) begin
      if (i < script.size()) begin
        coin_valid = script[i].coin;
        coin_value = 4'(script[i].v);
        cancel     = script[i].cancel;
      end
      tick();
      coin_valid = 1'b0; coin_value = 4'd0; cancel = 1'b0;
    end
    wait_idle();
    script.delete();
  endtask

  // Monitor: pops one expectation whenever a result appears on the outputs.
  initial begin
    int rej, kind, hold;
    bit rs;
    exp_t e;
    rej = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rej = 0;
      end else begin
        if (coin_reject) rej++;
        if (release_product || back_money || err_code != 2'd0) begin
          chk("result_expected", int'(expq.size() > 0), 1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            kind = release_product ? 0 : (back_money ? 1 : 2);
            chk("kind", kind, e.kind);
            chk("change", change, e.chg);
            chk("val_tot", val_tot, e.vt);
            chk("err_code", err_code, e.err);
            chk("id_sel", id_sel, e.id);
            chk("coin_rejects", rej, e.rej);
            chk("release_and_back", int'(release_product && back_money), 0);
          end
          hold = 1;
          rs = 0;
          while (hold < 100) begin
            @(negedge clk);
            if (rst) rs = 1;
            if (!(release_product || back_money || err_code != 2'd0)) break;
            hold++;
          end
          if (!rs) chk("hold_cycles", hold, HOLD);
          chk("after_state", state_now, 0);
          chk("after_outputs",
              int'({val_tot, change, id_sel, release_product, back_money, err_code, coin_reject}), 0);
          rej = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 16; i++) begin price_tab[i] = 4'd0; avail_tab[i] = 1'b0; end
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; coin_valid = 1'b0;
    coin_value = 4'd0; cancel = 1'b0;
    tick();
    chk("reset_state", state_now, 0);
    chk("reset_data", int'({id_sel, val_tot, change, err_code}), 0);
    chk("reset_flags", int'({release_product, back_money, coin_reject}), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_reset_state", state_now, 0);

    // Exact payment
    add(1, 2, 0); add(1, 4, 0);
    run_txn(3, 6, 1, 0, 0);
    // Overpay
    add(1, 5, 0); add(1, 5, 0);
    run_txn(4, 7, 1, 0, 0);
    // Overflowing coin rejected
    add(1, 8, 0); add(1, 15, 0); add(1, 1, 0);
    run_txn(1, 9, 1, 0, 0);
    // Invalid ID and out of stock
    run_txn(12, 5, 1, 0, 0);
    run_txn(2, 5, 0, 0, 0);
    // Timeout with credit, timeout without credit, cancel with coin
    add(1, 3, 0);
    run_txn(5, 6, 1, 0, 0);
    run_txn(6, 6, 1, 0, 0);
    add(1, 2, 0); add(1, 4, 1);
    run_txn(7, 9, 1, 0, 0);
    // Coin on the terminal timeout cycle is accepted and restarts the timer
    add(1, 2, 0);
    for (int i = 0; i < TMO - 1; i++) add(0, 0, 0);
    add(1, 1, 0);
    run_txn(8, 9, 1, 0, 0);
    // Free product, coins in IDLE and CHECK rejected
    run_txn(0, 0, 1, 1, 1);

    for (int n = 0; n < 40; n++) begin
      int id, pr, mode, len;
      bit av, pc, cc;
      id   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
      av   = ($urandom_range(0, 4) != 0);
      pr   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      pc   = ($urandom_range(0, 3) == 0);
      cc   = ($urandom_range(0, 3) == 0);
      mode = $urandom_range(0, 2);
      len  = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        bit c;
        int v;
        c = (mode == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        v = ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(1, 8);
        add(c, v, (mode == 1) && (i == len - 1));
      end
      run_txn(id, pr, av, pc, cc);
    end

    // Reset in the second dispense cycle, with a key press alongside it
    price_tab[3] = 4'd6; avail_tab[3] = 1'b1;
    e.kind = 0; e.chg = 0; e.vt = 6; e.err = 0; e.id = 3; e.rej = 0;
    expq.push_back(e);
    key_valid = 1'b1; key_code = 4'd3;
    tick();
    key_valid = 1'b0; key_code = 4'd0;
    tick();
    coin_valid = 1'b1; coin_value = 4'd2;
    tick();
    coin_value = 4'd4;
    tick();
    coin_valid = 1'b0; coin_value = 4'd0;
    chk("mid_reset_dispensing", release_product, 1);
    tick();
    rst = 1'b1; key_valid = 1'b1; key_code = 4'd5;
    tick();
    rst = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    chk("mid_reset_release", release_product, 0);
    chk("mid_reset_state", state_now, 0);
    chk("mid_reset_val_tot", val_tot, 0);
    chk("mid_reset_id_sel", id_sel, 0);
    tick();
    chk("mid_reset_key_ignored", state_now, 0);

    repeat (5) tick();
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
